// File: rtl/pa_ifu_icache_tag_ctrl_if.sv
// Bundle of the icache tag-array controller's request, handshake and SRAM port signals.
// master = tag controller side, slave = requesters plus the tag array.
interface pa_ifu_icache_tag_ctrl_if;
  logic        cp0_ifu_icache_inv_req;
  logic        ifu_cp0_icache_inv_done;
  logic        ifu_icache_tag_busy;
  logic        refill_tag_wr_req;
  logic [9:0]  refill_tag_wr_idx;
  logic [21:0] refill_tag_wr_tag;
  logic        refill_tag_wr_way;
  logic        refill_tag_wr_ack;
  logic        fetch_tag_rd_req;
  logic [9:0]  fetch_tag_rd_idx;
  logic        fetch_tag_rd_gnt;
  logic        icache_tag_cen;
  logic [2:0]  icache_tag_wen;
  logic [9:0]  icache_tag_idx;
  logic [46:0] icache_tag_din;

  modport master (
    input  cp0_ifu_icache_inv_req,
    input  refill_tag_wr_req,
    input  refill_tag_wr_idx,
    input  refill_tag_wr_tag,
    input  refill_tag_wr_way,
    input  fetch_tag_rd_req,
    input  fetch_tag_rd_idx,
    output ifu_cp0_icache_inv_done,
    output ifu_icache_tag_busy,
    output refill_tag_wr_ack,
    output fetch_tag_rd_gnt,
    output icache_tag_cen,
    output icache_tag_wen,
    output icache_tag_idx,
    output icache_tag_din
  );

  modport slave (
    output cp0_ifu_icache_inv_req,
    output refill_tag_wr_req,
    output refill_tag_wr_idx,
    output refill_tag_wr_tag,
    output refill_tag_wr_way,
    output fetch_tag_rd_req,
    output fetch_tag_rd_idx,
    input  ifu_cp0_icache_inv_done,
    input  ifu_icache_tag_busy,
    input  refill_tag_wr_ack,
    input  fetch_tag_rd_gnt,
    input  icache_tag_cen,
    input  icache_tag_wen,
    input  icache_tag_idx,
    input  icache_tag_din
  );
endinterface

// File: rtl/pa_ifu_icache_tag_ctrl.sv
// Icache tag-array port controller: arbitrates refill writes, fetch reads and the
// invalidate-all walk (cp0-requested or automatic after reset) onto one SRAM port.
module pa_ifu_icache_tag_ctrl #(
  parameter int IDX_W = 10,
  parameter int TAG_W = 22
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  pa_ifu_icache_tag_ctrl_if.master tag_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] CNT_MAX  = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] CNT_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] CNT_STEP = IDX_W'(1'b1);
  localparam logic [9:0]       IDX_MASK = 10'((11'd1 << IDX_W) - 11'd1);

  state_t           state_r, state_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;
  logic             walk_pend_r, walk_pend_s;
  logic             cp0_walk_r, cp0_walk_s;

  logic        cen_s;
  logic [2:0]  wen_s;
  logic [9:0]  idx_s;
  logic [46:0] din_s;
  logic        ack_s;
  logic        gnt_s;
  logic        inv_done_s;
  logic        inv_req_s;

  // Refill word: selected way gets vld+tag, fifo points at the other way as next victim.
  function automatic logic [46:0] refill_word(input logic way, input logic [21:0] tag);
    logic [21:0] field;
    field = 22'd0;
    field[TAG_W-1:0] = tag[TAG_W-1:0];
    refill_word = way ? {1'b0, 1'b1, field, 1'b0, 22'd0}
                      : {1'b1, 1'b0, 22'd0, 1'b1, field};
  endfunction

  assign inv_req_s = tag_bus.cp0_ifu_icache_inv_req;

  // Controller state registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      walk_pend_r <= 1'b1;
      cp0_walk_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      walk_pend_r <= walk_pend_s;
      cp0_walk_r  <= cp0_walk_s;
    end
  end

  // Next-state logic; a request during a walk restarts it rather than queueing a second one.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    walk_pend_s = walk_pend_r;
    cp0_walk_s  = cp0_walk_r;
    case (state_r)
      IDLE: begin
        if (walk_pend_r || inv_req_s) begin
          state_s     = WALK;
          cnt_s       = CNT_ZERO;
          walk_pend_s = 1'b0;
          cp0_walk_s  = cp0_walk_r | inv_req_s;
        end else begin
          state_s = IDLE;
        end
      end
      WALK: begin
        if (inv_req_s) begin
          cnt_s      = CNT_ZERO;
          cp0_walk_s = 1'b1;
        end else if (cnt_r == CNT_MAX) begin
          cnt_s   = CNT_ZERO;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CNT_STEP;
        end
      end
      DONE: begin
        state_s     = walk_pend_r ? WALK : IDLE;
        cnt_s       = CNT_ZERO;
        walk_pend_s = inv_req_s;
        cp0_walk_s  = inv_req_s;
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = CNT_ZERO;
        walk_pend_s = 1'b1;
        cp0_walk_s  = 1'b0;
      end
    endcase
  end

  // Array port drive and requester handshakes; refill wins over fetch in IDLE.
  always_comb begin
    cen_s      = 1'b0;
    wen_s      = 3'b000;
    idx_s      = 10'd0;
    din_s      = 47'd0;
    ack_s      = 1'b0;
    gnt_s      = 1'b0;
    inv_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tag_bus.refill_tag_wr_req) begin
          cen_s = 1'b1;
          ack_s = 1'b1;
          idx_s = tag_bus.refill_tag_wr_idx & IDX_MASK;
          wen_s = {1'b1, tag_bus.refill_tag_wr_way, ~tag_bus.refill_tag_wr_way};
          din_s = refill_word(tag_bus.refill_tag_wr_way, tag_bus.refill_tag_wr_tag);
        end else if (tag_bus.fetch_tag_rd_req) begin
          cen_s = 1'b1;
          gnt_s = 1'b1;
          idx_s = tag_bus.fetch_tag_rd_idx & IDX_MASK;
        end else begin
          cen_s = 1'b0;
        end
      end
      WALK: begin
        cen_s = 1'b1;
        wen_s = 3'b111;
        idx_s = 10'(cnt_r);
      end
      DONE: begin
        inv_done_s = cp0_walk_r;
      end
      default: begin
        cen_s = 1'b0;
      end
    endcase
  end

  assign tag_bus.icache_tag_cen          = cen_s;
  assign tag_bus.icache_tag_wen          = wen_s;
  assign tag_bus.icache_tag_idx          = idx_s;
  assign tag_bus.icache_tag_din          = din_s;
  assign tag_bus.refill_tag_wr_ack       = ack_s;
  assign tag_bus.fetch_tag_rd_gnt        = gnt_s;
  assign tag_bus.ifu_cp0_icache_inv_done = inv_done_s;
  assign tag_bus.ifu_icache_tag_busy     = walk_pend_r | (state_r != IDLE);

endmodule

// File: tb/tb_pa_ifu_icache_tag_ctrl.sv
// Directed self-checking bench for pa_ifu_icache_tag_ctrl with a 16-set array.
module tb_pa_ifu_icache_tag_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  localparam logic [46:0] DIN_W1 = {1'b0, 1'b1, 22'h12345, 1'b0, 22'h000000};
  localparam logic [46:0] DIN_W0 = {1'b1, 1'b0, 22'h000000, 1'b1, 22'h2abcd};

  pa_ifu_icache_tag_ctrl_if bus ();

  pa_ifu_icache_tag_ctrl #(.IDX_W(4), .TAG_W(22)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .tag_bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Sixteen walk cycles, first one starting at the next negedge.
  task automatic walk_16(input string nm);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.cp0_ifu_icache_inv_req = 1'b0;
      #1;
      chk({nm, "_cen"},  64'(bus.icache_tag_cen), 64'd1);
      chk({nm, "_wen"},  64'(bus.icache_tag_wen), 64'd7);
      chk({nm, "_idx"},  64'(bus.icache_tag_idx), 64'(i));
      chk({nm, "_din"},  64'(bus.icache_tag_din), 64'd0);
      chk({nm, "_done"}, 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
      chk({nm, "_gnt"},  64'(bus.fetch_tag_rd_gnt), 64'd0);
      chk({nm, "_ack"},  64'(bus.refill_tag_wr_ack), 64'd0);
    end
  endtask

  task automatic reset_outputs(input string nm);
    chk({nm, "_cen"},  64'(bus.icache_tag_cen), 64'd0);
    chk({nm, "_wen"},  64'(bus.icache_tag_wen), 64'd0);
    chk({nm, "_busy"}, 64'(bus.ifu_icache_tag_busy), 64'd1);
    chk({nm, "_done"}, 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk({nm, "_ack"},  64'(bus.refill_tag_wr_ack), 64'd0);
    chk({nm, "_gnt"},  64'(bus.fetch_tag_rd_gnt), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus.cp0_ifu_icache_inv_req = 1'b0;
    bus.refill_tag_wr_req      = 1'b0;
    bus.refill_tag_wr_idx      = 10'd0;
    bus.refill_tag_wr_tag      = 22'd0;
    bus.refill_tag_wr_way      = 1'b0;
    bus.fetch_tag_rd_req       = 1'b0;
    bus.fetch_tag_rd_idx       = 10'd0;

    // Reset values, then the automatic power-on walk.
    @(negedge clk); @(negedge clk); #1;
    reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_outputs("por_c1");
    walk_16("por");
    @(negedge clk); #1;
    chk("por_done_c18", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("por_busy_c18", 64'(bus.ifu_icache_tag_busy), 64'd1);
    chk("por_cen_c18",  64'(bus.icache_tag_cen), 64'd0);
    @(negedge clk); #1;
    chk("por_busy_c19", 64'(bus.ifu_icache_tag_busy), 64'd0);
    chk("idle_cen",     64'(bus.icache_tag_cen), 64'd0);
    chk("idle_idx",     64'(bus.icache_tag_idx), 64'd0);
    chk("idle_din",     64'(bus.icache_tag_din), 64'd0);

    // Refill way1 then way0.
    @(negedge clk);
    bus.refill_tag_wr_req = 1'b1;
    bus.refill_tag_wr_way = 1'b1;
    bus.refill_tag_wr_idx = 10'd5;
    bus.refill_tag_wr_tag = 22'h12345;
    #1;
    chk("rf1_ack", 64'(bus.refill_tag_wr_ack), 64'd1);
    chk("rf1_cen", 64'(bus.icache_tag_cen), 64'd1);
    chk("rf1_wen", 64'(bus.icache_tag_wen), 64'd6);
    chk("rf1_idx", 64'(bus.icache_tag_idx), 64'd5);
    chk("rf1_din", 64'(bus.icache_tag_din), 64'(DIN_W1));
    @(negedge clk);
    bus.refill_tag_wr_way = 1'b0;
    bus.refill_tag_wr_idx = 10'd3;
    bus.refill_tag_wr_tag = 22'h2abcd;
    #1;
    chk("rf0_ack", 64'(bus.refill_tag_wr_ack), 64'd1);
    chk("rf0_wen", 64'(bus.icache_tag_wen), 64'd5);
    chk("rf0_idx", 64'(bus.icache_tag_idx), 64'd3);
    chk("rf0_din", 64'(bus.icache_tag_din), 64'(DIN_W0));

    // Fetch alone.
    @(negedge clk);
    bus.refill_tag_wr_req = 1'b0;
    bus.fetch_tag_rd_req  = 1'b1;
    bus.fetch_tag_rd_idx  = 10'd9;
    #1;
    chk("fe_gnt", 64'(bus.fetch_tag_rd_gnt), 64'd1);
    chk("fe_cen", 64'(bus.icache_tag_cen), 64'd1);
    chk("fe_wen", 64'(bus.icache_tag_wen), 64'd0);
    chk("fe_idx", 64'(bus.icache_tag_idx), 64'd9);
    chk("fe_ack", 64'(bus.refill_tag_wr_ack), 64'd0);

    // Refill and fetch together: refill first, fetch next cycle.
    @(negedge clk);
    bus.refill_tag_wr_req = 1'b1;
    bus.refill_tag_wr_way = 1'b1;
    bus.refill_tag_wr_idx = 10'd12;
    bus.fetch_tag_rd_idx  = 10'd4;
    #1;
    chk("both1_ack", 64'(bus.refill_tag_wr_ack), 64'd1);
    chk("both1_gnt", 64'(bus.fetch_tag_rd_gnt), 64'd0);
    chk("both1_idx", 64'(bus.icache_tag_idx), 64'd12);
    @(negedge clk);
    bus.refill_tag_wr_req = 1'b0;
    #1;
    chk("both2_gnt", 64'(bus.fetch_tag_rd_gnt), 64'd1);
    chk("both2_idx", 64'(bus.icache_tag_idx), 64'd4);

    // cp0 invalidate with a fetch held throughout.
    @(negedge clk);
    bus.cp0_ifu_icache_inv_req = 1'b1;
    #1;
    chk("inv_t_busy", 64'(bus.ifu_icache_tag_busy), 64'd0);
    chk("inv_t_gnt",  64'(bus.fetch_tag_rd_gnt), 64'd1);
    walk_16("inv");
    @(negedge clk); #1;
    chk("inv_done_t17", 64'(bus.ifu_cp0_icache_inv_done), 64'd1);
    chk("inv_gnt_t17",  64'(bus.fetch_tag_rd_gnt), 64'd0);
    chk("inv_busy_t17", 64'(bus.ifu_icache_tag_busy), 64'd1);
    @(negedge clk); #1;
    chk("inv_done_t18", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("inv_gnt_t18",  64'(bus.fetch_tag_rd_gnt), 64'd1);
    chk("inv_busy_t18", 64'(bus.ifu_icache_tag_busy), 64'd0);

    // Restart the walk with a second request at cnt=7.
    @(negedge clk);
    bus.fetch_tag_rd_req       = 1'b0;
    bus.cp0_ifu_icache_inv_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.cp0_ifu_icache_inv_req = (i == 7) ? 1'b1 : 1'b0;
      #1;
      chk("rs_pre_idx",  64'(bus.icache_tag_idx), 64'(i));
      chk("rs_pre_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    end
    walk_16("rs");
    @(negedge clk); #1;
    chk("rs_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd1);
    @(negedge clk); #1;
    chk("rs_done_after", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("rs_busy_after", 64'(bus.ifu_icache_tag_busy), 64'd0);

    // Request landing in DONE: current pulse fires, then a second walk and pulse.
    @(negedge clk);
    bus.cp0_ifu_icache_inv_req = 1'b1;
    walk_16("dn1");
    @(negedge clk);
    bus.cp0_ifu_icache_inv_req = 1'b1;
    #1;
    chk("dn1_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd1);
    @(negedge clk);
    bus.cp0_ifu_icache_inv_req = 1'b0;
    #1;
    chk("dn_gap_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("dn_gap_busy", 64'(bus.ifu_icache_tag_busy), 64'd1);
    chk("dn_gap_cen",  64'(bus.icache_tag_cen), 64'd0);
    walk_16("dn2");
    @(negedge clk); #1;
    chk("dn2_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd1);
    @(negedge clk); #1;
    chk("dn2_busy_after", 64'(bus.ifu_icache_tag_busy), 64'd0);

    // Reset in the middle of a cp0 walk: no pulse, fresh auto walk.
    @(negedge clk);
    bus.cp0_ifu_icache_inv_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.cp0_ifu_icache_inv_req = 1'b0;
      #1;
      chk("mr_pre_idx", 64'(bus.icache_tag_idx), 64'(i));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_outputs("mr_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_outputs("mr_c1");
    walk_16("mr");
    @(negedge clk); #1;
    chk("mr_done", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("mr_busy", 64'(bus.ifu_icache_tag_busy), 64'd1);
    @(negedge clk); #1;
    chk("mr_done_after", 64'(bus.ifu_cp0_icache_inv_done), 64'd0);
    chk("mr_busy_after", 64'(bus.ifu_icache_tag_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
